// File: rtl/lock_pkg.sv
// Shared lock encodings and the LED thermometer helper.
// The helper is used by the lock LED indicator and its sub-blocks.
package lock_pkg;

    localparam int MAX_LEDS = 16;
    localparam int CNT5_W   = 5;

    typedef enum logic [1:0] {
        WAITING  = 2'b00,
        EDITING  = 2'b01,
        UNLOCKED = 2'b10,
        ALARMING = 2'b11
    } lock_state_e;

    typedef enum logic {
        ADMIN = 1'b0,
        USER  = 1'b1
    } role_e;

    // Lights the lowest 'count' bits; callers truncate to their LED width.
    function automatic logic [MAX_LEDS-1:0] therm_encode(input logic [CNT5_W-1:0] count);
        logic [MAX_LEDS-1:0] t;
        t = '0;
        for (int i = 0; i < MAX_LEDS; i++) begin
            t[i] = (i < int'(count));
        end
        return t;
    endfunction

endpackage

// File: rtl/state_indicate_blink_blink_timer.sv
// Alarm flash prescaler: half-period counter plus on/off phase toggle.
// The restart cycle is treated as count position 0 of a fresh on-phase.
module blink_timer #(
    parameter  int BLINK_HALF = 25_000_000,
    localparam int BLINK_W    = $clog2(BLINK_HALF)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic restart,
    output logic phase
);

    logic [BLINK_W-1:0] r_cnt_p0;
    logic               r_on_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_p0 <= '0;
            r_on_p0  <= 1'b1;
        end else if (!run) begin
            r_cnt_p0 <= '0;
            r_on_p0  <= 1'b1;
        end else if (restart) begin
            r_cnt_p0 <= BLINK_W'(1);
            r_on_p0  <= 1'b1;
        end else if (r_cnt_p0 == BLINK_W'(BLINK_HALF - 1)) begin
            r_cnt_p0 <= '0;
            r_on_p0  <= ~r_on_p0;
        end else begin
            r_cnt_p0 <= r_cnt_p0 + BLINK_W'(1);
        end
    end

    assign phase = restart ? 1'b1 : r_on_p0;

endmodule

// File: rtl/state_indicate_blink.sv
// Registered LED indicator for the lock FSM: one-hot idle, digit bar while editing,
// all-on when unlocked, timed flash when alarming, with a lamp-test override.
module state_indicate_blink
    import lock_pkg::*;
#(
    parameter  int N_LEDS     = 4,
    parameter  int BLINK_HALF = 25_000_000,
    localparam int BLINK_W    = $clog2(BLINK_HALF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        state,
    input  logic              digit_pulse,
    input  logic              lamp_test,
    output logic [N_LEDS-1:0] LEDs
);

    localparam int EC_W = $clog2(N_LEDS);

    if (BLINK_W < 1 || N_LEDS < 2 || N_LEDS > MAX_LEDS) begin : g_param_check
        $error("state_indicate_blink: illegal N_LEDS or BLINK_HALF");
    end

    function automatic logic [EC_W-1:0] sat_inc(input logic [EC_W-1:0] v);
        if (v >= EC_W'(N_LEDS - 1)) begin
            return v;
        end
        return v + EC_W'(1);
    endfunction

    lock_state_e       r_prev_state_p0;
    logic [EC_W-1:0]   r_edit_cnt_p0;
    logic [N_LEDS-1:0] r_leds_p1;

    logic              w_entry;
    logic              w_alarm;
    logic              w_phase;
    logic [EC_W-1:0]   w_edit_nxt;
    logic [N_LEDS-1:0] w_leds_nxt;

    blink_timer #(
        .BLINK_HALF (BLINK_HALF)
    ) u_blink_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (w_alarm),
        .restart (w_entry),
        .phase   (w_phase)
    );

    // Stage p0: previous state and digit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_state_p0 <= WAITING;
            r_edit_cnt_p0   <= '0;
        end else begin
            r_prev_state_p0 <= lock_state_e'(state);
            r_edit_cnt_p0   <= w_edit_nxt;
        end
    end

    // A digit on the editing entry cycle is counted on top of the clear.
    always_comb begin
        w_entry    = (state != r_prev_state_p0);
        w_alarm    = (state == ALARMING);
        w_edit_nxt = r_edit_cnt_p0;
        if (state == EDITING) begin
            if (w_entry) begin
                w_edit_nxt = digit_pulse ? EC_W'(1) : '0;
            end else if (digit_pulse) begin
                w_edit_nxt = sat_inc(r_edit_cnt_p0);
            end
        end
    end

    always_comb begin
        w_leds_nxt = '0;
        case (lock_state_e'(state))
            WAITING:  w_leds_nxt = N_LEDS'(1);
            EDITING:  w_leds_nxt = N_LEDS'(therm_encode(CNT5_W'(w_edit_nxt) + CNT5_W'(1)));
            UNLOCKED: w_leds_nxt = '1;
            ALARMING: w_leds_nxt = {N_LEDS{w_phase}};
            default:  w_leds_nxt = '0;
        endcase
        if (lamp_test) begin
            w_leds_nxt = '1;
        end
    end

    // Stage p1: registered LED drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_leds_p1 <= '0;
        end else begin
            r_leds_p1 <= w_leds_nxt;
        end
    end

    assign LEDs = r_leds_p1;

endmodule

// File: tb/tb_state_indicate_blink.sv
// Directed bench for state_indicate_blink with N_LEDS=4, BLINK_HALF=4.
module tb_state_indicate_blink;
    import lock_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [1:0] state;
    logic       digit_pulse;
    logic       lamp_test;
    logic [3:0] LEDs;

    int checks = 0;
    int errors = 0;

    state_indicate_blink #(
        .N_LEDS     (4),
        .BLINK_HALF (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .state       (state),
        .digit_pulse (digit_pulse),
        .lamp_test   (lamp_test),
        .LEDs        (LEDs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] exp);
        checks++;
        assert (LEDs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, LEDs, exp);
        end
    endtask

    function automatic logic [3:0] flash(input int n);
        return ((n % 8) < 4) ? 4'b1111 : 4'b0000;
    endfunction

    initial begin
        logic [3:0] bar [5];
        bar[0] = 4'b0011; bar[1] = 4'b0111; bar[2] = 4'b1111;
        bar[3] = 4'b1111; bar[4] = 4'b1111;

        rst_n = 1'b0; state = WAITING; digit_pulse = 1'b0; lamp_test = 1'b0;
        #12;
        chk("reset_leds", 4'b0000);
        #5 rst_n = 1'b1;
        tick();
        chk("waiting_after_reset", 4'b0001);

        // editing bar with saturation
        state = EDITING;
        tick();
        chk("edit_entry", 4'b0001);
        for (int i = 0; i < 5; i++) begin
            digit_pulse = 1'b1;
            tick();
            digit_pulse = 1'b0;
            chk($sformatf("edit_digit%0d", i + 1), bar[i]);
            tick();
            chk($sformatf("edit_hold%0d", i + 1), bar[i]);
        end
        state = WAITING;
        tick();
        chk("back_to_waiting", 4'b0001);
        digit_pulse = 1'b1;
        tick();
        digit_pulse = 1'b0;
        chk("digit_ignored_waiting", 4'b0001);
        state = EDITING;
        tick();
        chk("edit_reentry_cleared", 4'b0001);
        state = WAITING;
        tick();
        state = EDITING; digit_pulse = 1'b1;
        tick();
        digit_pulse = 1'b0;
        chk("edit_entry_with_digit", 4'b0011);

        // alarm flash over five periods
        state = ALARMING;
        for (int n = 0; n < 40; n++) begin
            tick();
            chk($sformatf("alarm_n%0d", n), flash(n));
        end
        for (int n = 40; n < 45; n++) begin
            tick();
            chk($sformatf("alarm_n%0d", n), flash(n));
        end

        // leave mid off-phase, then re-enter for a full on-phase
        state = UNLOCKED;
        tick();
        chk("unlocked_from_alarm", 4'b1111);
        state = ALARMING;
        for (int n = 0; n < 12; n++) begin
            tick();
            chk($sformatf("realarm_n%0d", n), flash(n));
        end

        // lamp test across the off-phase keeps the flash alignment
        lamp_test = 1'b1;
        for (int n = 12; n < 15; n++) begin
            tick();
            chk($sformatf("lamp_n%0d", n), 4'b1111);
        end
        lamp_test = 1'b0;
        for (int n = 15; n < 24; n++) begin
            tick();
            chk($sformatf("post_lamp_n%0d", n), flash(n));
        end

        // async reset while editing with two digits counted
        state = EDITING;
        tick();
        chk("edit_before_reset", 4'b0001);
        digit_pulse = 1'b1;
        tick();
        digit_pulse = 1'b0;
        chk("edit_cnt1", 4'b0011);
        digit_pulse = 1'b1;
        tick();
        digit_pulse = 1'b0;
        chk("edit_cnt2", 4'b0111);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset_blank", 4'b0000);
        tick();
        chk("reset_held", 4'b0000);
        rst_n = 1'b1;
        tick();
        chk("edit_after_reset", 4'b0001);
        digit_pulse = 1'b1;
        tick();
        digit_pulse = 1'b0;
        chk("edit_after_reset_digit", 4'b0011);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
